// File: rtl/fc_accum12.sv
// 12-lane signed frame accumulator with IDLE/ACCUM/HOLD handshake to a comparator stage.
// Define FC_ACCUM_SAT_EN for saturating lane adds; the default build wraps modulo 2^`DATA_LEN.
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

module fc_accum12 #(
  parameter int MAX_BEATS = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [12*`DATA_LEN-1:0]   din,
  output logic                      in_ready,
  input  logic                      ack,
  output logic [12*`DATA_LEN-1:0]   acc,
  output logic                      load,
  output logic [7:0]                beats
);

  localparam int DW = `DATA_LEN;
  localparam int NL = 12;
  localparam logic [7:0] MAX_B = 8'(MAX_BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NL*DW-1:0]   acc_q, acc_d;
  logic [7:0]         beats_q, beats_d;
  logic               in_ready_q, in_ready_d;
  logic               load_q, load_d;

  // Lanes are independent; the saturating form detects overflow from the sign-extended sum.
  function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef FC_ACCUM_SAT_EN
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1]) begin
      lane_add = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      lane_add = s[DW-1:0];
    end
`else
    lane_add = a + b;
`endif
  endfunction

  // Next-state, accumulator and handshake-flag computation.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    beats_d = beats_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          acc_d   = {(NL*DW){1'b0}};
          beats_d = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (start) begin
          // Restart wins over a coincident beat.
          acc_d   = {(NL*DW){1'b0}};
          beats_d = 8'd0;
        end else if (in_valid) begin
          for (int i = 0; i < NL; i++) begin
            acc_d[i*DW +: DW] = lane_add(acc_q[i*DW +: DW], din[i*DW +: DW]);
          end
          beats_d = beats_q + 8'd1;
          if (in_last || (beats_d == MAX_B)) begin
            state_d = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      HOLD: begin
        if (ack) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d = (state_d == ACCUM);
    load_d     = (state_d == HOLD);
  end

  // State, result and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= {(NL*DW){1'b0}};
      beats_q    <= 8'd0;
      in_ready_q <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      beats_q    <= beats_d;
      in_ready_q <= in_ready_d;
      load_q     <= load_d;
    end
  end

  assign in_ready = in_ready_q;
  assign load     = load_q;
  assign acc      = acc_q;
  assign beats    = beats_q;

endmodule

// File: doc/fc_accum12.md
FC_ACCUM12 -- requirements
Module: fc_accum12

Interface
REQ-001 Parameter MAX_BEATS, default 64, maximum beats accumulated per frame (1..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle pulse; clears accumulators and opens a frame.
REQ-005 in_valid  input  1  din beat is valid.
REQ-006 in_last  input  1  qualifies the final beat of a frame; sampled only with in_valid.
REQ-007 din  input  12*`data_len  12 signed two's-complement partial-product lanes; lane i at bits [i*`data_len +: `data_len].
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 ack  input  1  downstream comparator-stage valid; releases the held result.
REQ-010 acc  output  12*`data_len  registered 12-lane accumulated result, same lane packing as din.
REQ-011 load  output  1  result-held strobe to the downstream comparator stage; stays high until ack.
REQ-012 beats  output  8  number of beats accepted in the current or last frame.

Function
REQ-013 The block SHALL implement three states: IDLE, ACCUM and HOLD.
REQ-014 IDLE: in_ready=0 and load=0; start -> ACCUM, with acc and beats cleared to 0 on the same edge.
REQ-015 ACCUM: in_ready=1; on a beat (in_valid & in_ready), every lane i SHALL update acc_i <= acc_i + din_i and beats <= beats+1.
REQ-016 ACCUM: a beat with in_last=1, or the beat that makes beats equal MAX_BEATS, SHALL be added and the state SHALL move to HOLD on the same edge.
REQ-017 HOLD: in_ready=0 and load=1 from the cycle after the last beat; acc SHALL remain stable while load=1.
REQ-018 HOLD: ack sampled high -> IDLE; load SHALL be 0 in the following cycle; acc and beats SHALL retain their values.
REQ-019 Accumulation latency: a beat accepted at edge t SHALL be visible on acc after edge t.
REQ-020 start in ACCUM SHALL restart the frame: acc=0 and beats=0, any coincident beat is discarded, and the state stays ACCUM.
REQ-021 start in HOLD SHALL be ignored; in_valid in IDLE or HOLD SHALL be ignored without changing state.
REQ-022 ack outside HOLD SHALL be ignored.
REQ-023 Lane arithmetic SHALL be `data_len wide with no carry between lanes; overflow handling is as set by REQ-027.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state=IDLE, acc=0, beats=0, load=0 and in_ready=0.
REQ-025 Reset asserted mid-frame or in HOLD SHALL discard the frame; after release, no output SHALL change until start.
REQ-026 Release of rst_n SHALL be treated as synchronous to clk; start in the first post-release cycle SHALL be honoured.

Configuration
REQ-027 When FC_ACCUM_SAT_EN is defined, each lane add SHALL saturate to the signed limits: max = 2^(`data_len-1)-1, min = -2^(`data_len-1).
REQ-028 When FC_ACCUM_SAT_EN is undefined, each lane add SHALL wrap modulo 2^`data_len.
REQ-029 FC_ACCUM_SAT_EN SHALL change no other behaviour, port or latency.

Verification
REQ-030 Frame test: start, then 3 beats with all lanes = 1, 2, 3 and in_last on the third beat -> next cycle load=1, every lane of acc = 6, beats = 3; ack -> load=0 one cycle later.
REQ-031 MAX_BEATS=4, five beats with in_last never set -> HOLD entered after the 4th beat, beats=4, the 5th beat is not accepted (in_ready=0).
REQ-032 Lane 0 at max positive value, then a beat adding 1 -> with FC_ACCUM_SAT_EN lane 0 = max; without it lane 0 = min; all other lanes are unaffected.
REQ-033 start pulsed after 2 beats in ACCUM, coincident with a valid beat -> acc=0 and beats=0 afterwards; a new 1-beat frame then yields acc = din.
REQ-034 rst_n pulsed low while in HOLD -> load, acc and beats drop to 0 immediately without a clock edge; a later ack has no effect.
REQ-035 ack held high throughout a frame -> load pulses for exactly one cycle after the last beat; in_valid in IDLE never changes acc.
